muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit. It sits beside the combinational RV32I ALU in the execute stage and handles the M-extension ops that the ALU cannot do in one cycle.
- Takes operands through a valid/ready request port, computes over multiple cycles, and returns one result through a valid/ready response port.
- The execute stage stalls on it using the handshakes.

Parameters:
- N_BITS, 32, operand/result width; only 32 is supported for RV32M.
- CNT_W, $clog2(N_BITS)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any in-flight op (pipeline squash)
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- md_op  in  3  md_op_t, M-extension funct3 encoding
- in0  in  N_BITS  rs1 value (multiplicand/dividend)
- in1  in  N_BITS  rs2 value (multiplier/divisor)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- out  out  N_BITS  result

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, out=0, counter=0, internal registers=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: req_ready=1. When req_valid&&!flush, latch md_op, compute operand magnitudes and sign flags, and go to BUSY (normal op) or DONE (special case).
  - BUSY: req_ready=0. Runs one iteration per cycle for N_BITS cycles, counter N_BITS-1 down to 0. After the last iteration, apply the sign fixup and go to DONE.
  - DONE: resp_valid=1. Hold out stable until resp_ready, then go to IDLE. No new request is accepted in DONE.
- Latency:
  - Request handshake in cycle T gives resp_valid at T+N_BITS+1 (33 for RV32).
  - Special cases give resp_valid at T+1.
  - Back-to-back: the next request can be accepted in the cycle after the response handshake.
- Op encoding:
  - 000 MUL: low 32 bits of the product.
  - 001 MULH: high 32 bits, signed x signed.
  - 010 MULHSU: high 32 bits, signed x unsigned.
  - 011 MULHU: high 32 bits, unsigned x unsigned.
  - 100 DIV: signed quotient. 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder. 111 REMU: unsigned remainder.
- Multiply:
  - Radix-2 shift-add on unsigned magnitudes, with a 2*N_BITS accumulator.
  - The product is negated when the operand signs differ (signed operands only).
- Divide:
  - Restoring division on magnitudes; the remainder register is N_BITS+1 bits wide.
  - Quotient is negated if the signs differ (DIV). Remainder takes the dividend's sign (REM).
- Special cases (resolved in IDLE, no iteration):
  - Divide by zero: quotient = all ones (0xFFFFFFFF); remainder = in0.
  - Signed overflow (DIV/REM with in0=0x80000000, in1=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Zero operands take the normal path; no early-out.
- flush:
  - Takes priority over every other event in any state: next state IDLE, resp_valid=0, the in-flight result is discarded.
  - In IDLE, flush and req_valid together: the request is not accepted (req_ready is still shown as 1, but no handshake occurs).
- Reset mid-operation: returns immediately to the reset values. No stale response follows.
- Inputs are sampled only at the request handshake. in0/in1 may change freely afterwards.

Decomposition:
- core_types_pkg gains md_op_t (3-bit enum: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) and md_state_t (IDLE, BUSY, DONE).
- One natural sub-module: muldiv_step, a combinational single iteration with two modes:
  - shift-add: conditional add of the multiplicand, then shift of the accumulator.
  - restoring subtract: trial subtract, quotient bit, conditional restore.
- muldiv_unit owns the FSM, counter, sign handling and the special cases.

Test Plan:
- MUL in0=0x00000007, in1=0xFFFFFFFD -> out=0xFFFFFFEB; resp_valid exactly 33 cycles after the request handshake.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Each of these has resp_valid one cycle after the handshake.
- Response backpressure: hold resp_ready=0 for 10 cycles -> out stable, req_ready=0 throughout; assert resp_ready -> req_ready=1 next cycle; a back-to-back DIVU 9/3 returns 3.
- Assert flush at BUSY cycle 10 (and separately pulse rst_n low in BUSY) -> resp_valid never rises for that op; the next MUL 3x4 returns 12 with full latency.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared execute-stage types: M-extension op encoding (funct3) and the
// multiply/divide unit's FSM states.
package core_types_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic op_is_div(input md_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add for multiply, or one
// restoring-division step (quotient built in the low half of acc).
module muldiv_step #(
  parameter int N_BITS = 32
) (
  input  logic                  div_mode,
  input  logic [2*N_BITS-1:0]   acc_in,
  input  logic [N_BITS:0]       rem_in,
  input  logic [N_BITS-1:0]     operand,
  output logic [2*N_BITS-1:0]   acc_out,
  output logic [N_BITS:0]       rem_out
);

  logic [N_BITS:0] sum;
  logic [N_BITS:0] rem_shift;
  logic [N_BITS:0] trial;
  logic            q_bit;

  always_comb begin
    sum       = {1'b0, acc_in[2*N_BITS-1:N_BITS]} +
                (acc_in[0] ? {1'b0, operand} : '0);
    // remainder never exceeds N_BITS bits, so dropping the top bit is lossless
    rem_shift = (N_BITS+1)'({rem_in, acc_in[N_BITS-1]});
    trial     = rem_shift - {1'b0, operand};
    q_bit     = ~trial[N_BITS];

    if (div_mode) begin
      acc_out = {acc_in[2*N_BITS-1:N_BITS], acc_in[N_BITS-2:0], q_bit};
      rem_out = q_bit ? trial : rem_shift;
    end else begin
      acc_out = {sum, acc_in[N_BITS-1:1]};
      rem_out = rem_in;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response
// ports; one iteration per cycle, special divide cases resolved at accept.
module muldiv_unit
  import core_types_pkg::*;
#(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  md_op_t            md_op,
  input  logic [N_BITS-1:0] in0,
  input  logic [N_BITS-1:0] in1,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_BITS-1:0] out
);

  localparam int CNT_W = $clog2(N_BITS) + 1;

  md_state_t           state_reg, state_next;
  md_op_t              op_reg, op_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [2*N_BITS-1:0] acc_reg, acc_next;
  logic [N_BITS:0]     rem_reg, rem_next;
  logic [N_BITS-1:0]   opnd_reg, opnd_next;
  logic                neg_reg, neg_next;
  logic [N_BITS-1:0]   out_reg, out_next;

  logic [2*N_BITS-1:0] step_acc, prod_fix;
  logic [N_BITS:0]     step_rem;
  logic [N_BITS-1:0]   quo_fix, rem_fix;
  logic                a_signed, b_signed, a_neg, b_neg;
  logic [N_BITS-1:0]   mag0, mag1;
  logic                div_zero, div_ovf;

  muldiv_step #(.N_BITS(N_BITS)) u_step (
    .div_mode (op_is_div(op_reg)),
    .acc_in   (acc_reg),
    .rem_in   (rem_reg),
    .operand  (opnd_reg),
    .acc_out  (step_acc),
    .rem_out  (step_rem)
  );

  always_comb begin
    a_signed = (md_op == MULH) || (md_op == MULHSU) || (md_op == DIV) || (md_op == REM);
    b_signed = (md_op == MULH) || (md_op == DIV) || (md_op == REM);
    a_neg    = a_signed & in0[N_BITS-1];
    b_neg    = b_signed & in1[N_BITS-1];
    mag0     = a_neg ? -in0 : in0;
    mag1     = b_neg ? -in1 : in1;
    div_zero = op_is_div(md_op) && (in1 == '0);
    div_ovf  = ((md_op == DIV) || (md_op == REM)) &&
               (in0 == {1'b1, {(N_BITS-1){1'b0}}}) && (in1 == '1);
    prod_fix = neg_reg ? -step_acc : step_acc;
    quo_fix  = neg_reg ? -step_acc[N_BITS-1:0] : step_acc[N_BITS-1:0];
    rem_fix  = neg_reg ? -step_rem[N_BITS-1:0] : step_rem[N_BITS-1:0];
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    opnd_next  = opnd_reg;
    neg_next   = neg_reg;
    out_next   = out_reg;
    req_ready  = (state_reg == IDLE);
    resp_valid = (state_reg == DONE);

    case (state_reg)
      IDLE: begin
        if (req_valid && !flush) begin
          op_next = md_op;
          if (div_zero) begin
            out_next   = md_op[1] ? in0 : '1;
            state_next = DONE;
          end else if (div_ovf) begin
            out_next   = md_op[1] ? '0 : {1'b1, {(N_BITS-1){1'b0}}};
            state_next = DONE;
          end else begin
            // multiply: multiplier sits in acc low half; divide: dividend does
            acc_next   = {{N_BITS{1'b0}}, op_is_div(md_op) ? mag0 : mag1};
            opnd_next  = op_is_div(md_op) ? mag1 : mag0;
            rem_next   = '0;
            neg_next   = md_op[1] && op_is_div(md_op) ? a_neg : (a_neg ^ b_neg);
            cnt_next   = CNT_W'(N_BITS - 1);
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        acc_next = step_acc;
        rem_next = step_rem;
        if (cnt_reg == '0) begin
          case (op_reg)
            MUL:       out_next = prod_fix[N_BITS-1:0];
            DIV, DIVU: out_next = quo_fix;
            REM, REMU: out_next = rem_fix;
            default:   out_next = prod_fix[2*N_BITS-1:N_BITS];
          endcase
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= MUL;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      opnd_reg  <= '0;
      neg_reg   <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      opnd_reg  <= opnd_next;
      neg_reg   <= neg_next;
      out_reg   <= out_next;
    end
  end

  assign out = out_reg;

endmodule
